// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through receive FIFO
//   clk       system clock
//   reset     asynchronous active-low reset
//   rxd       serial input, idle high
//   rd_en     pop FIFO head (ignored when empty)
//   err_clr   clear sticky overrun/frame_err
//   rd_data   FIFO head byte, 8'h00 when empty
//   rx_valid  FIFO not empty
//   rx_full   FIFO holds FIFO_DEPTH entries
//   overrun   sticky: byte dropped on full FIFO
//   frame_err sticky: stop bit sampled low
//   busy      receiver not idle
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   input  logic       rd_en,
   input  logic       err_clr,
   output logic [7:0] rd_data,
   output logic       rx_valid,
   output logic       rx_full,
   output logic       overrun,
   output logic       frame_err,
   output logic       busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] bit_last  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] half_last = CW'(CLKS_PER_BIT / 2 - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
   state_t state, nstate;
   logic rx_meta, rxs;
   logic [CW-1:0] cnt;
   logic [2:0] idx;
   logic [7:0] shreg;
   logic tick, push, ferr_set;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0] count;
   logic pop, wr, ovr_set;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rxs     <= rx_meta;
      end
   // sample point: mid start bit in START, mid bit in DATA/STOP
   assign tick = (state == START && cnt == half_last) ||
                 ((state == DATA || state == STOP) && cnt == bit_last);
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= nstate;
   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (!rxs) nstate = START;
         START:   if (tick) nstate = rxs ? IDLE : DATA;
         DATA:    if (tick && idx == 3'd7) nstate = STOP;
         STOP:    if (tick) nstate = rxs ? IDLE : BREAK;
         BREAK:   if (rxs) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end
   always_comb begin
      busy     = state != IDLE;
      push     = state == STOP && tick && rxs;
      ferr_set = state == STOP && tick && !rxs;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         cnt <= (state == IDLE || state == BREAK || tick) ? '0 : cnt + CW'(1);
         if (state == START) idx <= '0;
         else if (state == DATA && tick) idx <= idx + 3'd1;
         if (state == DATA && tick) shreg <= {rxs, shreg[7:1]};
      end
   assign rx_valid = count != '0;
   assign rx_full  = count == (AW+1)'(FIFO_DEPTH);
   assign pop      = rd_en && rx_valid;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the byte
   assign wr       = push && (!rx_full || pop);
   assign ovr_set  = push && rx_full && !pop;
   assign rd_data  = rx_valid ? mem[rptr] : 8'h00;
   always_ff @(posedge clk)
      if (wr) mem[wptr] <= shreg;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         wptr      <= wptr + AW'(wr);
         rptr      <= rptr + AW'(pop);
         count     <= count + (AW+1)'(wr) - (AW+1)'(pop);
         overrun   <= ovr_set | (overrun & ~err_clr);
         frame_err <= ferr_set | (frame_err & ~err_clr);
      end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scoreboard bench for uart_rx_fifo (16 clks/bit, depth 4)
module tb_uart_rx_fifo;
   logic clk = 1'b0, reset = 1'b0, rxd = 1'b1, rd_en = 1'b0, err_clr = 1'b0;
   logic [7:0] rd_data;
   logic rx_valid, rx_full, overrun, frame_err, busy;
   int checks = 0, errors = 0;
   logic [7:0] q[$];
   always #10 clk = ~clk;
   uart_rx_fifo #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .rxd(rxd), .rd_en(rd_en), .err_clr(err_clr),
      .rd_data(rd_data), .rx_valid(rx_valid), .rx_full(rx_full),
      .overrun(overrun), .frame_err(frame_err), .busy(busy)
   );
   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask
   task automatic check_bit(input string tag, input logic obs, input logic want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, want);
      end
   endtask
   task automatic check_zero(input string tag);
      check_bit({tag, "_rx_valid"}, rx_valid, 1'b0);
      check_bit({tag, "_rx_full"}, rx_full, 1'b0);
      check_bit({tag, "_overrun"}, overrun, 1'b0);
      check_bit({tag, "_frame_err"}, frame_err, 1'b0);
      check_bit({tag, "_busy"}, busy, 1'b0);
      check({tag, "_rd_data"}, rd_data, 8'h00);
   endtask
   function automatic logic fbit(input logic [7:0] d, input logic stop, input int i);
      return i < 16 ? 1'b0 : i < 144 ? d[3'((i - 16) / 16)] : stop;
   endfunction
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask
   // one 160-cycle frame; the DUT samples the stop bit on the posedge after step 154
   task automatic send(input logic [7:0] d, input logic stop, input logic exp_push, input logic pop_at_push);
      for (int i = 0; i < 160; i++) begin
         rxd = fbit(d, stop, i);
         rd_en = pop_at_push && i == 154;
         if (i == 88) check_bit("busy_mid_frame", busy, 1'b1);
         if (pop_at_push && i == 154) check("pop_at_push_head", rd_data, q.pop_front());
         @(negedge clk);
      end
      rd_en = 1'b0;
      if (exp_push) q.push_back(d);
   endtask
   task automatic pop_check(input string tag);
      logic [7:0] want;
      want = q.size() > 0 ? q.pop_front() : 8'hxx;
      check_bit({tag, "_valid"}, rx_valid, 1'b1);
      check({tag, "_data"}, rd_data, want);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask
   initial begin
      idle(3);
      check_zero("reset");
      reset = 1'b1;
      idle(5);
      send(8'hA5, 1'b1, 1'b1, 1'b0);
      check_bit("a5_busy_after", busy, 1'b0);
      pop_check("a5");
      check_bit("a5_empty", rx_valid, 1'b0);
      check("a5_rd_zero", rd_data, 8'h00);
      send(8'h01, 1'b1, 1'b1, 1'b0);
      send(8'h80, 1'b1, 1'b1, 1'b0);
      send(8'hFF, 1'b1, 1'b1, 1'b0);
      send(8'h00, 1'b1, 1'b1, 1'b0);
      check_bit("b2b_full", rx_full, 1'b1);
      check_bit("b2b_overrun", overrun, 1'b0);
      check_bit("b2b_frame_err", frame_err, 1'b0);
      repeat (4) pop_check("b2b");
      check_bit("b2b_empty", rx_valid, 1'b0);
      send(8'h11, 1'b1, 1'b1, 1'b0);
      send(8'h22, 1'b1, 1'b1, 1'b0);
      send(8'h33, 1'b1, 1'b1, 1'b0);
      send(8'h44, 1'b1, 1'b1, 1'b0);
      send(8'h3C, 1'b1, 1'b0, 1'b0);
      check_bit("ovr_set", overrun, 1'b1);
      check_bit("ovr_full", rx_full, 1'b1);
      repeat (4) pop_check("ovr");
      check_bit("ovr_empty", rx_valid, 1'b0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check_bit("ovr_clr", overrun, 1'b0);
      send(8'h55, 1'b1, 1'b1, 1'b0);
      send(8'h66, 1'b1, 1'b1, 1'b0);
      send(8'h77, 1'b1, 1'b1, 1'b0);
      send(8'h88, 1'b1, 1'b1, 1'b0);
      send(8'h3C, 1'b1, 1'b1, 1'b1);
      check_bit("popush_no_ovr", overrun, 1'b0);
      check_bit("popush_full", rx_full, 1'b1);
      repeat (4) pop_check("popush");
      check_bit("popush_empty", rx_valid, 1'b0);
      rxd = 1'b0;
      idle(5);
      check_bit("glitch_busy", busy, 1'b1);
      rxd = 1'b1;
      idle(20);
      check_bit("glitch_idle", busy, 1'b0);
      check_bit("glitch_no_push", rx_valid, 1'b0);
      check_bit("glitch_frame_err", frame_err, 1'b0);
      check_bit("glitch_overrun", overrun, 1'b0);
      send(8'h55, 1'b0, 1'b0, 1'b0);
      idle(100);
      check_bit("brk_frame_err", frame_err, 1'b1);
      check_bit("brk_busy", busy, 1'b1);
      check_bit("brk_no_push", rx_valid, 1'b0);
      rxd = 1'b1;
      idle(5);
      check_bit("brk_exit", busy, 1'b0);
      send(8'h55, 1'b1, 1'b1, 1'b0);
      pop_check("after_brk");
      check_bit("ferr_sticky", frame_err, 1'b1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check_bit("ferr_clr", frame_err, 1'b0);
      for (int i = 0; i < 88; i++) begin
         rxd = fbit(8'hF0, 1'b1, i);
         @(negedge clk);
      end
      check_bit("midframe_busy", busy, 1'b1);
      reset = 1'b0;
      rxd = 1'b1;
      #1;
      check_zero("in_reset");
      idle(3);
      reset = 1'b1;
      idle(40);
      check_zero("after_reset");
      send(8'hC3, 1'b1, 1'b1, 1'b0);
      pop_check("c3");
      check_bit("final_empty", rx_valid, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
